// File: rtl/av_mem_slave_pkg.sv
// Shared Avalon-MM definitions (package av_common): response codes, op codes, burst FSM states.
package av_common;

  localparam logic [1:0] RESPONSE_OKAY       = 2'b00;
  localparam logic [1:0] RESPONSE_SLAVEERROR = 2'b10;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } av_op_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2
  } av_state_e;

  function automatic logic [1:0] resp_for(input logic err);
    return err ? RESPONSE_SLAVEERROR : RESPONSE_OKAY;
  endfunction

endpackage

// File: rtl/av_mem_slave_ram.sv
// Single-port synchronous RAM, DEPTH x DW, per-byte write enable, registered 1-cycle read.
module av_mem_slave_ram #(
  parameter int DW    = 32,
  parameter int DEPTH = 1024
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic                     i_re,
  input  logic [DW/8-1:0]          i_be,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [DW-1:0]            i_wdata,
  output logic [DW-1:0]            o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < DW/8; b++) begin
        if (i_be[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/av_mem_slave.sv
// Avalon-MM burst slave on byte-enabled RAM with programmable wait states and read latency.
// Optional AV_MEM_SLAVE_ERR_EN: out-of-range beats error out instead of wrapping modulo DEPTH.
//   state    | meaning
//   IDLE     | waiting for a command; beat 0 of any burst is handled here
//   WR_BURST | accepting write beats 1..n-1, each after WAIT_STATES stall cycles
//   RD_BURST | issuing one RAM read per cycle for beats 1..n-1, waitrequest held high
module av_mem_slave
  import av_common::*;
#(
  parameter int dw          = 32,
  parameter int aw          = 32,
  parameter int burstw      = 8,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0,
  parameter int RD_LATENCY  = 1
) (
  input  logic              av_clk_i,
  input  logic              av_rst_n_i,
  input  logic [aw-1:0]     av_address_i,
  input  logic [dw-1:0]     av_writedata_i,
  input  logic [dw/8-1:0]   av_byteenable_i,
  input  logic [burstw-1:0] av_burstcount_i,
  input  logic              av_write_i,
  input  logic              av_read_i,
  output logic              av_waitrequest_o,
  output logic              av_readdatavalid_o,
  output logic [1:0]        av_response_o,
  output logic [dw-1:0]     av_readdata_o,
  output logic              av_err_o
);

  localparam int                BSHIFT = $clog2(dw/8);
  localparam int                RAW    = $clog2(DEPTH);
  localparam logic [3:0]        WS     = 4'(WAIT_STATES);
  localparam logic [aw-1:0]     AW_ONE = aw'(1);
  localparam logic [burstw-1:0] BC_ONE = burstw'(1);

  av_state_e         r_state, w_state_nxt;
  av_op_e            w_op;
  logic              r_active;
  logic [3:0]        r_wcnt, w_wcnt_nxt;
  logic [aw-1:0]     r_addr, w_addr_nxt, w_idx, w_in_idx;
  logic [burstw-1:0] r_count, w_count_nxt, w_bc;
  logic              w_we, w_re, w_ram_we, w_rd_err;
  logic              r_v0, r_e0;
  logic [dw-1:0]     w_ram_rdata, w_s0_data;
  logic [1:0]        w_s0_resp;

  assign w_in_idx = av_address_i >> BSHIFT;
  assign w_bc     = (av_burstcount_i == '0) ? BC_ONE : av_burstcount_i;
  assign w_op     = av_write_i ? OP_WRITE : OP_READ;

  always_ff @(posedge av_clk_i or negedge av_rst_n_i) begin
    if (!av_rst_n_i) begin
      r_state  <= IDLE;
      r_active <= 1'b0;
      r_wcnt   <= WS;
      r_addr   <= '0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_active <= 1'b1;
      r_wcnt   <= w_wcnt_nxt;
      r_addr   <= w_addr_nxt;
      r_count  <= w_count_nxt;
    end
  end

  // Beat 0 is served straight from the bus address so a 1-cycle read latency is reachable.
  always_comb begin
    w_state_nxt      = r_state;
    w_wcnt_nxt       = r_wcnt;
    w_addr_nxt       = r_addr;
    w_count_nxt      = r_count;
    w_idx            = r_addr;
    w_we             = 1'b0;
    w_re             = 1'b0;
    av_waitrequest_o = 1'b1;
    unique case (r_state)
      IDLE: begin
        if (r_active && (av_read_i || av_write_i)) begin
          if (r_wcnt != 4'd0) begin
            w_wcnt_nxt = r_wcnt - 4'd1;
          end else begin
            av_waitrequest_o = 1'b0;
            w_wcnt_nxt       = WS;
            w_idx            = w_in_idx;
            w_addr_nxt       = w_in_idx + AW_ONE;
            w_count_nxt      = w_bc - BC_ONE;
            if (w_op == OP_WRITE) begin
              w_we = 1'b1;
              if (w_bc > BC_ONE) w_state_nxt = WR_BURST;
            end else begin
              w_re = 1'b1;
              if (w_bc > BC_ONE) w_state_nxt = RD_BURST;
            end
          end
        end
      end
      WR_BURST: begin
        if (av_write_i) begin
          if (r_wcnt != 4'd0) begin
            w_wcnt_nxt = r_wcnt - 4'd1;
          end else begin
            av_waitrequest_o = 1'b0;
            w_wcnt_nxt       = WS;
            w_we             = 1'b1;
            w_addr_nxt       = r_addr + AW_ONE;
            if (r_count != '0) w_count_nxt = r_count - BC_ONE;
            if (r_count <= BC_ONE) w_state_nxt = IDLE;
          end
        end
      end
      RD_BURST: begin
        w_re       = 1'b1;
        w_addr_nxt = r_addr + AW_ONE;
        if (r_count != '0) w_count_nxt = r_count - BC_ONE;
        if (r_count <= BC_ONE) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef AV_MEM_SLAVE_ERR_EN
  localparam logic [aw-1:0] DEPTH_AW = aw'(DEPTH);
  logic w_oor;
  logic r_err;

  assign w_oor    = (w_idx >= DEPTH_AW);
  assign w_ram_we = w_we & ~w_oor;
  assign w_rd_err = w_re & w_oor;

  always_ff @(posedge av_clk_i or negedge av_rst_n_i) begin
    if (!av_rst_n_i) r_err <= 1'b0;
    else             r_err <= (w_we | w_re) & w_oor;
  end

  assign av_err_o = r_err;
`else
  logic w_unused_idx;

  assign w_unused_idx = ^w_idx;
  assign w_ram_we     = w_we;
  assign w_rd_err     = 1'b0;
  assign av_err_o     = 1'b0;
`endif

  av_mem_slave_ram #(
    .DW    (dw),
    .DEPTH (DEPTH)
  ) u_ram (
    .i_clk   (av_clk_i),
    .i_we    (w_ram_we),
    .i_re    (w_re),
    .i_be    (av_byteenable_i),
    .i_addr  (w_idx[RAW-1:0]),
    .i_wdata (av_writedata_i),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge av_clk_i or negedge av_rst_n_i) begin
    if (!av_rst_n_i) begin
      r_v0 <= 1'b0;
      r_e0 <= 1'b0;
    end else begin
      r_v0 <= w_re;
      r_e0 <= w_rd_err;
    end
  end

  assign w_s0_data = (r_v0 && !r_e0) ? w_ram_rdata : '0;
  assign w_s0_resp = resp_for(r_e0);

  generate
    if (RD_LATENCY == 1) begin : g_lat1
      assign av_readdatavalid_o = r_v0;
      assign av_readdata_o      = w_s0_data;
      assign av_response_o      = w_s0_resp;
    end else begin : g_latn
      localparam int N = RD_LATENCY - 1;
      logic [N-1:0]  r_v;
      logic [dw-1:0] r_d [N];
      logic [1:0]    r_r [N];

      always_ff @(posedge av_clk_i or negedge av_rst_n_i) begin
        if (!av_rst_n_i) begin
          r_v <= '0;
          for (int k = 0; k < N; k++) begin
            r_d[k] <= '0;
            r_r[k] <= RESPONSE_OKAY;
          end
        end else begin
          r_v[0] <= r_v0;
          r_d[0] <= w_s0_data;
          r_r[0] <= w_s0_resp;
          for (int k = 1; k < N; k++) begin
            r_v[k] <= r_v[k-1];
            r_d[k] <= r_d[k-1];
            r_r[k] <= r_r[k-1];
          end
        end
      end

      assign av_readdatavalid_o = r_v[N-1];
      assign av_readdata_o      = r_d[N-1];
      assign av_response_o      = r_r[N-1];
    end
  endgenerate

endmodule

// File: tb/tb_av_mem_slave.sv
// Scoreboard bench for av_mem_slave: instance A (WS=0, LAT=1, DEPTH=1024), instance B (WS=3, LAT=4, DEPTH=16).
module tb_av_mem_slave;
  import av_common::*;

  localparam int LAT_A = 1;
  localparam int LAT_B = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_rst_n, a_wr, a_rd, a_wait, a_rdv, a_err;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [3:0]  a_be;
  logic [7:0]  a_bc;
  logic [1:0]  a_resp;
  logic        b_rst_n, b_wr, b_rd, b_wait, b_rdv, b_err;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [3:0]  b_be;
  logic [7:0]  b_bc;
  logic [1:0]  b_resp;

  av_mem_slave #(.dw(32), .aw(32), .burstw(8), .DEPTH(1024), .WAIT_STATES(0), .RD_LATENCY(LAT_A)) u_a (
    .av_clk_i(clk), .av_rst_n_i(a_rst_n), .av_address_i(a_addr), .av_writedata_i(a_wdata),
    .av_byteenable_i(a_be), .av_burstcount_i(a_bc), .av_write_i(a_wr), .av_read_i(a_rd),
    .av_waitrequest_o(a_wait), .av_readdatavalid_o(a_rdv), .av_response_o(a_resp),
    .av_readdata_o(a_rdata), .av_err_o(a_err));

  av_mem_slave #(.dw(32), .aw(32), .burstw(8), .DEPTH(16), .WAIT_STATES(3), .RD_LATENCY(LAT_B)) u_b (
    .av_clk_i(clk), .av_rst_n_i(b_rst_n), .av_address_i(b_addr), .av_writedata_i(b_wdata),
    .av_byteenable_i(b_be), .av_burstcount_i(b_bc), .av_write_i(b_wr), .av_read_i(b_rd),
    .av_waitrequest_o(b_wait), .av_readdatavalid_o(b_rdv), .av_response_o(b_resp),
    .av_readdata_o(b_rdata), .av_err_o(b_err));

  typedef struct {
    logic [31:0] d;
    logic [1:0]  r;
    int          c;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int checks = 0;
  int errors = 0;
  int a_errs = 0;
  int b_errs = 0;
  logic [31:0] wbuf  [8];
  logic [31:0] rexp  [8];
  logic [1:0]  rresp [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  exp_t ea, eb;
  always @(negedge clk) begin
    if (a_err) a_errs++;
    if (a_rst_n) begin
      if (a_rdv) begin
        if (qa.size() == 0) chk("a_rdv_unexpected", {31'b0, a_rdv}, 32'd0);
        else begin
          ea = qa.pop_front();
          chk("a_rdata", a_rdata, ea.d);
          chk("a_resp", {30'b0, a_resp}, {30'b0, ea.r});
          chk("a_rdv_cycle", cyc, ea.c);
        end
      end else chk("a_rdata_idle_zero", a_rdata, 32'd0);
    end
  end

  always @(negedge clk) begin
    if (b_err) b_errs++;
    if (b_rst_n) begin
      if (b_rdv) begin
        if (qb.size() == 0) chk("b_rdv_unexpected", {31'b0, b_rdv}, 32'd0);
        else begin
          eb = qb.pop_front();
          chk("b_rdata", b_rdata, eb.d);
          chk("b_resp", {30'b0, b_resp}, {30'b0, eb.r});
          chk("b_rdv_cycle", cyc, eb.c);
        end
      end else chk("b_rdata_idle_zero", b_rdata, 32'd0);
    end
  end

  task automatic drive(input int s, input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be, input logic [7:0] bc);
    if (s == 0) begin
      a_rd = rd; a_wr = wr; a_addr = addr; a_wdata = wd; a_be = be; a_bc = bc;
    end else begin
      b_rd = rd; b_wr = wr; b_addr = addr; b_wdata = wd; b_be = be; b_bc = bc;
    end
  endtask

  function automatic logic wq(input int s);
    return (s == 0) ? a_wait : b_wait;
  endfunction

  // Returns #1 after the accepting posedge; acc is that edge's cycle number.
  task automatic wait_accept(input int s, input string nm, output int acc, output int ws);
    int guard = 0;
    ws = 0;
    forever begin
      @(negedge clk);
      if (!wq(s)) break;
      ws++;
      guard++;
      if (guard > 200) begin
        chk({nm, "_accept_timeout"}, guard, 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    acc = cyc;
  endtask

  task automatic write_burst(input int s, input logic [31:0] addr, input int n, input logic [3:0] be,
                             input int stall_after, input int stall_n);
    int acc, ws;
    for (int i = 0; i < n; i++) begin
      drive(s, 1'b0, 1'b1, addr, wbuf[i], be, 8'(n));
      wait_accept(s, "wr", acc, ws);
      if (i == stall_after) begin
        drive(s, 1'b0, 1'b0, addr, wbuf[i], be, 8'(n));
        repeat (stall_n) @(posedge clk);
        #1;
      end
    end
    drive(s, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 8'd0);
  endtask

  task automatic read_burst(input int s, input logic [31:0] addr, input logic [7:0] bc, output int ws);
    int acc;
    int n;
    int lat;
    exp_t e;
    n   = (bc == 8'd0) ? 1 : int'(bc);
    lat = (s == 0) ? LAT_A : LAT_B;
    drive(s, 1'b1, 1'b0, addr, 32'd0, 4'hF, bc);
    wait_accept(s, "rd", acc, ws);
    drive(s, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 8'd0);
    for (int i = 0; i < n; i++) begin
      e.d = rexp[i];
      e.r = rresp[i];
      e.c = acc + lat - 1 + i;
      if (s == 0) qa.push_back(e);
      else        qb.push_back(e);
    end
  endtask

  task automatic drain();
    int g = 0;
    while ((qa.size() != 0 || qb.size() != 0) && g < 100) begin
      @(posedge clk);
      g++;
    end
    #1;
    chk("drain_queues", qa.size() + qb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int ws;
    a_rst_n = 1'b0;
    b_rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 8'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 8'd0);
    for (int i = 0; i < 8; i++) rresp[i] = RESPONSE_OKAY;
    repeat (2) @(posedge clk);
    #1;
    chk("a_rst_waitrequest", {31'b0, a_wait}, 32'd1);
    chk("a_rst_rdv", {31'b0, a_rdv}, 32'd0);
    chk("a_rst_resp", {30'b0, a_resp}, 32'd0);
    chk("a_rst_rdata", a_rdata, 32'd0);
    chk("a_rst_err", {31'b0, a_err}, 32'd0);
    chk("b_rst_waitrequest", {31'b0, b_wait}, 32'd1);
    chk("b_rst_rdv", {31'b0, b_rdv}, 32'd0);
    chk("b_rst_rdata", b_rdata, 32'd0);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // single write then read, data one cycle after the read accept
    wbuf[0] = 32'hDEADBEEF;
    write_burst(0, 32'h10, 1, 4'hF, -1, 0);
    rexp[0] = 32'hDEADBEEF;
    read_burst(0, 32'h10, 8'd1, ws);

    // byte-enable merge; read at unaligned address with burstcount 0
    wbuf[0] = 32'h11223344;
    write_burst(0, 32'h20, 1, 4'hF, -1, 0);
    wbuf[0] = 32'hAABBCCDD;
    write_burst(0, 32'h20, 1, 4'b0101, -1, 0);
    rexp[0] = 32'h11BB33DD;
    read_burst(0, 32'h23, 8'd0, ws);

    // 4-beat write with master stall after beat 1, then 4-beat back-to-back read
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    write_burst(0, 32'h100, 4, 4'hF, 1, 2);
    for (int i = 0; i < 4; i++) rexp[i] = 32'(i + 1);
    read_burst(0, 32'h100, 8'd4, ws);

    // wait states and longer latency on B
    wbuf[0] = 32'hCAFEF00D;
    write_burst(1, 32'h10, 1, 4'hF, -1, 0);
    rexp[0] = 32'hCAFEF00D;
    read_burst(1, 32'h10, 8'd1, ws);
    chk("b_read_wait_states", ws, 32'd3);

    // burst crossing the end of a 16-word RAM
    for (int i = 0; i < 4; i++) wbuf[i] = 32'h5A000000 + 32'(i);
    write_burst(1, 32'h38, 4, 4'hF, -1, 0);
    rexp[0] = wbuf[0];
    rexp[1] = wbuf[1];
`ifdef AV_MEM_SLAVE_ERR_EN
    rexp[2] = 32'd0; rresp[2] = RESPONSE_SLAVEERROR;
    rexp[3] = 32'd0; rresp[3] = RESPONSE_SLAVEERROR;
`else
    rexp[2] = wbuf[2];
    rexp[3] = wbuf[3];
`endif
    read_burst(1, 32'h38, 8'd4, ws);
    drain();
    repeat (3) @(posedge clk);
    #1;
`ifdef AV_MEM_SLAVE_ERR_EN
    chk("b_err_pulses", b_errs, 32'd4);
`else
    chk("b_err_pulses", b_errs, 32'd0);
`endif
    for (int i = 0; i < 8; i++) rresp[i] = RESPONSE_OKAY;

    // reset in the middle of an 8-beat read
    for (int i = 0; i < 8; i++) wbuf[i] = 32'hA0 + 32'(i);
    write_burst(0, 32'h200, 8, 4'hF, -1, 0);
    for (int i = 0; i < 8; i++) rexp[i] = wbuf[i];
    read_burst(0, 32'h200, 8'd8, ws);
    repeat (2) @(posedge clk);
    #1;
    a_rst_n = 1'b0;
    #1;
    chk("a_midburst_rst_rdv", {31'b0, a_rdv}, 32'd0);
    chk("a_midburst_rst_waitrequest", {31'b0, a_wait}, 32'd1);
    chk("a_midburst_rst_rdata", a_rdata, 32'd0);
    chk("a_midburst_rst_resp", {30'b0, a_resp}, 32'd0);
    qa.delete();
    repeat (2) @(posedge clk);
    #1;
    a_rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rexp[0] = 32'hA1;
    read_burst(0, 32'h204, 8'd1, ws);

    drain();
    repeat (5) @(posedge clk);
    #1;
    chk("a_err_pulses", a_errs, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
